// File: rtl/turn_timer_ctrl.sv
// turn_timer_ctrl: per-turn countdown for the Connect-4 game controller.
//   A turn_start pulse begins a TURN_SECONDS countdown. A move_done pulse stops it.
//   When the countdown runs out, times_up is raised. game_over freezes the block until reset.
// Ports: clk, reset (sync, active-low); turn_start, move_done (pulses); pause, game_over (levels);
//   times_up, secs_left[3:0], running, warn (all registered).
// Optional macro WARN_BLINK_EN: warn blinks at 2 Hz inside the warn window instead of holding steady.
module turn_timer_ctrl #(
  parameter int CLK_HZ       = 50000000,
  parameter int TURN_SECONDS = 10,
  parameter int WARN_SECONDS = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       turn_start,
  input  logic       move_done,
  input  logic       pause,
  input  logic       game_over,
  output logic       times_up,
  output logic [3:0] secs_left,
  output logic       running,
  output logic       warn
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] TC = PW'(CLK_HZ - 1);
  localparam logic [3:0] TURN4 = 4'(TURN_SECONDS);
  localparam logic [3:0] WARN4 = 4'(WARN_SECONDS);

  typedef enum logic [2:0] {IDLE, RUN, PAUSED, EXPIRED, HALT} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] presc, presc_nxt;
  logic [3:0]    secs_nxt;
  logic          times_up_nxt, running_nxt, warn_nxt;
  logic          reload, count, tick, in_window;

`ifdef WARN_BLINK_EN
  localparam logic [PW-1:0] BT = PW'((CLK_HZ >= 4) ? (CLK_HZ / 4 - 1) : 0);
  logic [PW-1:0] bcnt, bcnt_nxt;
  logic          bph, bph_nxt;
`endif

  always_comb begin
    state_nxt    = state;
    times_up_nxt = times_up;
    reload       = 1'b0;
    count        = 1'b0;

    if (game_over) begin
      state_nxt    = HALT;
      times_up_nxt = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (turn_start) begin
            state_nxt = RUN;
            reload    = 1'b1;
          end
        end
        RUN, PAUSED: begin
          if (turn_start) begin
            state_nxt = RUN;
            reload    = 1'b1;
          end else if (move_done) begin
            state_nxt = IDLE;
            reload    = 1'b1;
          end else if (pause) begin
            state_nxt = PAUSED;
          end else begin
            // Leaving PAUSED counts in this same cycle, so the frozen time
            // equals the number of cycles pause was sampled high.
            state_nxt = RUN;
            count     = 1'b1;
          end
        end
        EXPIRED: begin
          if (turn_start) begin
            state_nxt    = RUN;
            reload       = 1'b1;
            times_up_nxt = 1'b0;
          end else if (move_done) begin
            state_nxt    = IDLE;
            reload       = 1'b1;
            times_up_nxt = 1'b0;
          end
        end
        HALT:    state_nxt = HALT;
        default: state_nxt = IDLE;
      endcase
    end

    tick      = count && (presc == TC);
    presc_nxt = presc;
    secs_nxt  = secs_left;
    if (reload) begin
      presc_nxt = '0;
      secs_nxt  = TURN4;
    end else if (count) begin
      presc_nxt = tick ? '0 : presc + 1'b1;
      if (tick && secs_left != 4'd0) begin
        secs_nxt = secs_left - 4'd1;
      end
    end

    // The last tick expires the turn. A move_done or turn_start arriving in the same cycle
    // takes priority, because count is never set when either of those is present.
    if (tick && secs_left == 4'd1) begin
      state_nxt    = EXPIRED;
      times_up_nxt = 1'b1;
    end

    running_nxt = (state_nxt == RUN);
    in_window   = ((state_nxt == RUN) || (state_nxt == PAUSED)) &&
                  (secs_nxt != 4'd0) && (secs_nxt <= WARN4);

`ifdef WARN_BLINK_EN
    // The blink phase restarts high at every new second.
    // It toggles every CLK_HZ/4 counted cycles, and it is frozen while counting is paused.
    bcnt_nxt = bcnt;
    bph_nxt  = bph;
    if (reload || tick) begin
      bcnt_nxt = '0;
      bph_nxt  = 1'b1;
    end else if (count) begin
      if (bcnt == BT) begin
        bcnt_nxt = '0;
        bph_nxt  = ~bph;
      end else begin
        bcnt_nxt = bcnt + 1'b1;
      end
    end
    warn_nxt = in_window && bph_nxt;
`else
    warn_nxt = in_window;
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      presc     <= '0;
      secs_left <= TURN4;
      times_up  <= 1'b0;
      running   <= 1'b0;
      warn      <= 1'b0;
    end else begin
      state     <= state_nxt;
      presc     <= presc_nxt;
      secs_left <= secs_nxt;
      times_up  <= times_up_nxt;
      running   <= running_nxt;
      warn      <= warn_nxt;
    end
  end

`ifdef WARN_BLINK_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      bcnt <= '0;
      bph  <= 1'b1;
    end else begin
      bcnt <= bcnt_nxt;
      bph  <= bph_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_turn_timer_ctrl.sv
// Directed bench for turn_timer_ctrl with CLK_HZ=4, TURN_SECONDS=3, WARN_SECONDS=1.
// Cycle n means the interval that starts at the n-th rising edge after the test's origin.
// Inputs are driven, and outputs are sampled, 1 time unit after that edge.
module tb_turn_timer_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       turn_start = 1'b0;
  logic       move_done = 1'b0;
  logic       pause = 1'b0;
  logic       game_over = 1'b0;
  logic       times_up, running, warn;
  logic [3:0] secs_left;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  turn_timer_ctrl #(.CLK_HZ(4), .TURN_SECONDS(3), .WARN_SECONDS(1)) dut (
    .clk(clk), .reset(reset), .turn_start(turn_start), .move_done(move_done),
    .pause(pause), .game_over(game_over), .times_up(times_up),
    .secs_left(secs_left), .running(running), .warn(warn)
  );

  always #5 clk = ~clk;

  task automatic adv(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic goto_cyc(input int n);
    while (cyc < n) adv(1);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s @cycle %0d: observed=%0d expected=%0d", tag, cyc, obs, expv);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    turn_start = 1'b0;
    move_done = 1'b0;
    pause = 1'b0;
    game_over = 1'b0;
    adv(1);
    reset = 1'b1;
    cyc = 0;
  endtask

  task automatic pulse_start();
    turn_start = 1'b1;
    adv(1);
    turn_start = 1'b0;
  endtask

  initial begin
    logic [3:0] es;
    logic       ew;
    logic       seen;

    // Reset state
    do_reset();
    chk("rst.secs", {4'd0, secs_left}, 8'd3);
    chk("rst.running", {7'd0, running}, 8'd0);
    chk("rst.times_up", {7'd0, times_up}, 8'd0);
    chk("rst.warn", {7'd0, warn}, 8'd0);

    // Pause and move_done are ignored in IDLE
    pause = 1'b1; move_done = 1'b1;
    adv(2);
    pause = 1'b0; move_done = 1'b0;
    chk("idle.running", {7'd0, running}, 8'd0);
    chk("idle.secs", {4'd0, secs_left}, 8'd3);

    // Basic countdown, turn_start at cycle 0
    do_reset();
    pulse_start();
    while (cyc <= 14) begin
      es = (cyc < 5) ? 4'd3 : (cyc < 9) ? 4'd2 : (cyc < 13) ? 4'd1 : 4'd0;
`ifdef WARN_BLINK_EN
      ew = (cyc == 9) || (cyc == 11);
`else
      ew = (cyc >= 9) && (cyc <= 12);
`endif
      chk("basic.secs", {4'd0, secs_left}, {4'd0, es});
      chk("basic.running", {7'd0, running}, {7'd0, (cyc < 13)});
      chk("basic.times_up", {7'd0, times_up}, {7'd0, (cyc >= 13)});
      chk("basic.warn", {7'd0, warn}, {7'd0, ew});
      adv(1);
    end

    // Expiry recovery: turn_start at cycle 15
    pulse_start();
    chk("recov.times_up16", {7'd0, times_up}, 8'd0);
    chk("recov.secs16", {4'd0, secs_left}, 8'd3);
    chk("recov.running16", {7'd0, running}, 8'd1);
    goto_cyc(27);
    chk("recov.times_up27", {7'd0, times_up}, 8'd0);
    chk("recov.secs27", {4'd0, secs_left}, 8'd1);
    goto_cyc(28);
    chk("recov.times_up28", {7'd0, times_up}, 8'd1);
    chk("recov.secs28", {4'd0, secs_left}, 8'd0);

    // Move before expiry: move_done at cycle 6
    do_reset();
    pulse_start();
    goto_cyc(6);
    move_done = 1'b1;
    adv(1);
    move_done = 1'b0;
    chk("move.running7", {7'd0, running}, 8'd0);
    chk("move.secs7", {4'd0, secs_left}, 8'd3);
    seen = 1'b0;
    while (cyc <= 30) begin
      seen = seen | times_up;
      adv(1);
    end
    chk("move.no_times_up", {7'd0, seen}, 8'd0);

    // Pause held high for cycles 3..10
    do_reset();
    pulse_start();
    goto_cyc(3);
    pause = 1'b1;
    adv(1);
    while (cyc <= 10) begin
      chk("pause.secs_frozen", {4'd0, secs_left}, 8'd3);
      adv(1);
    end
    pause = 1'b0;
    chk("pause.running11", {7'd0, running}, 8'd0);
    goto_cyc(12);
    chk("pause.running12", {7'd0, running}, 8'd1);
    chk("pause.secs12", {4'd0, secs_left}, 8'd3);
    goto_cyc(13);
    chk("pause.secs13", {4'd0, secs_left}, 8'd2);
    goto_cyc(17);
    chk("pause.warn17", {7'd0, warn}, 8'd1);
    goto_cyc(20);
    chk("pause.times_up20", {7'd0, times_up}, 8'd0);
    chk("pause.secs20", {4'd0, secs_left}, 8'd1);
    goto_cyc(21);
    chk("pause.times_up21", {7'd0, times_up}, 8'd1);
    chk("pause.secs21", {4'd0, secs_left}, 8'd0);

    // move_done in the same cycle as the final tick (cycle 12)
    do_reset();
    pulse_start();
    goto_cyc(12);
    chk("prio.secs12", {4'd0, secs_left}, 8'd1);
    move_done = 1'b1;
    adv(1);
    move_done = 1'b0;
    chk("prio.times_up13", {7'd0, times_up}, 8'd0);
    chk("prio.running13", {7'd0, running}, 8'd0);
    chk("prio.secs13", {4'd0, secs_left}, 8'd3);
    goto_cyc(16);
    chk("prio.times_up16", {7'd0, times_up}, 8'd0);

    // game_over together with turn_start at cycle 20 goes to HALT
    goto_cyc(20);
    game_over = 1'b1;
    turn_start = 1'b1;
    adv(1);
    game_over = 1'b0;
    turn_start = 1'b0;
    chk("halt.running21", {7'd0, running}, 8'd0);
    chk("halt.times_up21", {7'd0, times_up}, 8'd0);
    chk("halt.secs21", {4'd0, secs_left}, 8'd3);
    goto_cyc(23);
    pulse_start();
    chk("halt.ignore_start", {7'd0, running}, 8'd0);

    // One reset cycle leaves HALT
    reset = 1'b0;
    adv(1);
    reset = 1'b1;
    chk("halt.reset_secs", {4'd0, secs_left}, 8'd3);
    chk("halt.reset_running", {7'd0, running}, 8'd0);
    pulse_start();
    chk("halt.restart_running", {7'd0, running}, 8'd1);

    // HALT during a countdown freezes secs_left
    do_reset();
    pulse_start();
    goto_cyc(6);
    game_over = 1'b1;
    adv(1);
    game_over = 1'b0;
    chk("halt_mid.running", {7'd0, running}, 8'd0);
    goto_cyc(15);
    chk("halt_mid.secs", {4'd0, secs_left}, 8'd2);
    chk("halt_mid.times_up", {7'd0, times_up}, 8'd0);

    // Reset in the middle of a countdown
    do_reset();
    pulse_start();
    goto_cyc(6);
    reset = 1'b0;
    adv(1);
    reset = 1'b1;
    chk("rst_mid.secs", {4'd0, secs_left}, 8'd3);
    chk("rst_mid.running", {7'd0, running}, 8'd0);
    adv(5);
    chk("rst_mid.stay_idle", {4'd0, secs_left}, 8'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
